dsp_mac_pipe: RTL

DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

---
 rtl/dsp_mac_pkg.sv | 24 ++
 rtl/dsp_mac_postadd.sv | 107 ++++++++++
 rtl/dsp_mac_pipe.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared definitions for the dsp_mac_pipe multiply-accumulate pipeline:
// OPMODE bit positions, the Z-operand select encoding and the pipeline latency.
package dsp_mac_pkg;

  // Bit positions inside the 5-bit per-sample OPMODE word
  localparam int OP_PREADD  = 0;
  localparam int OP_PRESUB  = 1;
  localparam int OP_ZSEL_LO = 2;
  localparam int OP_ZSEL_HI = 3;
  localparam int OP_POSTSUB = 4;
  localparam int OPMODE_W   = 5;

  // Accepted sample to out_valid, counted in CE=1 clock edges
  localparam int MAC_LATENCY = 3;

  // Z operand of the post-adder
  typedef enum logic [1:0] {
    Z_ZERO = 2'b00,
    Z_C    = 2'b01,
    Z_P    = 2'b10,
    Z_PCIN = 2'b11
  } zsel_e;

endpackage

// File: rtl/dsp_mac_postadd.sv
// Stage 3 of dsp_mac_pipe: post-adder/subtractor with carry-out and the
// result register. The Z=P path feeds back from this module's own P register
// so back-to-back accumulations chain without a gap.
// Optional build macro: DSP_MAC_SAT_EN enables signed saturation and OVF.
module dsp_mac_postadd
  import dsp_mac_pkg::*;
#(
  parameter int AW = 18,
  parameter int BW = 18,
  parameter int PW = 48
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                ce,
  input  logic                i_valid,
  input  logic [AW+BW-1:0]    i_m,
  input  logic [PW-1:0]       i_c,
  input  logic [PW-1:0]       i_pcin,
  input  logic                i_cin,
  input  logic [OPMODE_W-1:0] i_op,
  output logic [PW-1:0]       o_p,
  output logic                o_carry,
  output logic                o_ovf,
  output logic                o_valid
);

  logic [PW-1:0] r_p;
  logic          r_carry;
  logic          r_valid;
  zsel_e         w_zsel;
  logic [PW-1:0] w_z;
  logic [PW-1:0] w_y;
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_res;
  logic [PW-1:0] w_p_next;

  assign w_zsel = zsel_e'(i_op[OP_ZSEL_HI:OP_ZSEL_LO]);

  // Z operand mux; Z_P uses the live result register
  always_comb begin
    w_z = '0;
    case (w_zsel)
      Z_ZERO: w_z = '0;
      Z_C:    w_z = i_c;
      Z_P:    w_z = r_p;
      Z_PCIN: w_z = i_pcin;
      default: w_z = '0;
    endcase
  end

  // Y is the sign-extended product plus carry-in; the unsigned PW+1-bit
  // sum/difference supplies CARRYOUT in its top bit
  assign w_y   = {{(PW-AW-BW){i_m[AW+BW-1]}}, i_m} + {{(PW-1){1'b0}}, i_cin};
  assign w_sum = i_op[OP_POSTSUB] ? ({1'b0, w_z} - {1'b0, w_y})
                                  : ({1'b0, w_z} + {1'b0, w_y});
  assign w_res = w_sum[PW-1:0];

`ifdef DSP_MAC_SAT_EN
  logic w_ovf;
  logic r_ovf;

  // Signed overflow: operands effectively of equal sign, result sign flipped
  always_comb begin
    if (i_op[OP_POSTSUB])
      w_ovf = (w_z[PW-1] != w_y[PW-1]) && (w_res[PW-1] != w_z[PW-1]);
    else
      w_ovf = (w_z[PW-1] == w_y[PW-1]) && (w_res[PW-1] != w_z[PW-1]);
    if (w_ovf)
      w_p_next = w_z[PW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    else
      w_p_next = w_res;
  end

  // Overflow flag register, updated alongside P
  always_ff @(posedge clk) begin
    if (srst)
      r_ovf <= 1'b0;
    else if (ce && i_valid)
      r_ovf <= w_ovf;
  end

  assign o_ovf = r_ovf;
`else
  assign w_p_next = w_res;
  assign o_ovf    = 1'b0;
`endif

  // Result register: P and CARRYOUT hold through bubbles
  always_ff @(posedge clk) begin
    if (srst) begin
      r_p     <= '0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else if (ce) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_p     <= w_p_next;
        r_carry <= w_sum[PW];
      end
    end
  end

  assign o_p     = r_p;
  assign o_carry = r_carry;
  assign o_valid = r_valid;

endmodule

// File: rtl/dsp_mac_pipe.sv
// Three-stage pre-add / multiply / post-add MAC pipeline with a global clock
// enable. OPMODE travels with each sample so modes can change every cycle.
// Optional build macro: DSP_MAC_SAT_EN (saturating post-adder with OVF).
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int AW = 18,
  parameter int BW = 18,
  parameter int PW = 48
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                CE,
  input  logic                in_valid,
  input  logic [AW-1:0]       A,
  input  logic [BW-1:0]       B,
  input  logic [BW-1:0]       D,
  input  logic [PW-1:0]       C,
  input  logic [PW-1:0]       PCIN,
  input  logic                CARRYIN,
  input  logic [OPMODE_W-1:0] OPMODE,
  output logic [BW-1:0]       BCOUT,
  output logic [AW+BW-1:0]    M,
  output logic [PW-1:0]       P,
  output logic [PW-1:0]       PCOUT,
  output logic                CARRYOUT,
  output logic                OVF,
  output logic                out_valid
);

  // Stage 1 registers
  logic                r1_valid;
  logic [AW-1:0]       r1_a;
  logic [BW-1:0]       r_bcout;
  logic [PW-1:0]       r1_c;
  logic [PW-1:0]       r1_pcin;
  logic                r1_cin;
  logic [OPMODE_W-1:0] r1_op;
  // Stage 2 registers
  logic                r2_valid;
  logic [AW+BW-1:0]    r_m;
  logic [PW-1:0]       r2_c;
  logic [PW-1:0]       r2_pcin;
  logic                r2_cin;
  logic [OPMODE_W-1:0] r2_op;

  logic [BW-1:0]       w_pre;
  logic [AW+BW-1:0]    w_a_ext;
  logic [AW+BW-1:0]    w_pre_ext;
  logic [AW+BW-1:0]    w_prod;

  // Pre-adder, wrapped to BW bits
  always_comb begin
    w_pre = B;
    if (OPMODE[OP_PREADD])
      w_pre = OPMODE[OP_PRESUB] ? (D - B) : (D + B);
  end

  // Sign-extend both factors to full width; the low AW+BW bits of the
  // product are then the correct signed result
  assign w_a_ext   = {{BW{r1_a[AW-1]}}, r1_a};
  assign w_pre_ext = {{AW{r_bcout[BW-1]}}, r_bcout};
  assign w_prod    = w_a_ext * w_pre_ext;

  // Stage 1: capture operands, mode and pre-adder result
  always_ff @(posedge clk) begin
    if (RST) begin
      r1_valid <= 1'b0;
      r1_a     <= '0;
      r_bcout  <= '0;
      r1_c     <= '0;
      r1_pcin  <= '0;
      r1_cin   <= 1'b0;
      r1_op    <= '0;
    end else if (CE) begin
      r1_valid <= in_valid;
      r1_a     <= A;
      r_bcout  <= w_pre;
      r1_c     <= C;
      r1_pcin  <= PCIN;
      r1_cin   <= CARRYIN;
      r1_op    <= OPMODE;
    end
  end

  // Stage 2: product register plus side-band operands
  always_ff @(posedge clk) begin
    if (RST) begin
      r2_valid <= 1'b0;
      r_m      <= '0;
      r2_c     <= '0;
      r2_pcin  <= '0;
      r2_cin   <= 1'b0;
      r2_op    <= '0;
    end else if (CE) begin
      r2_valid <= r1_valid;
      r_m      <= w_prod;
      r2_c     <= r1_c;
      r2_pcin  <= r1_pcin;
      r2_cin   <= r1_cin;
      r2_op    <= r1_op;
    end
  end

  dsp_mac_postadd #(
    .AW(AW),
    .BW(BW),
    .PW(PW)
  ) u_postadd (
    .clk     (clk),
    .srst    (RST),
    .ce      (CE),
    .i_valid (r2_valid),
    .i_m     (r_m),
    .i_c     (r2_c),
    .i_pcin  (r2_pcin),
    .i_cin   (r2_cin),
    .i_op    (r2_op),
    .o_p     (P),
    .o_carry (CARRYOUT),
    .o_ovf   (OVF),
    .o_valid (out_valid)
  );

  assign BCOUT = r_bcout;
  assign M     = r_m;
  assign PCOUT = P;

endmodule
